// File: rtl/fetch_pc_unit.sv
// IF-stage PC generator and fetcher: one outstanding imem request, IF/ID register, 1-entry skid buffer.
// Latency: req -> if_valid_o in 2 cycles with a 1-cycle memory; throughput 1 instr / 2 cycles.
// Backpressure: stall_i holds IF/ID; a response that can't load parks in the skid and blocks new reqs. Counters via FETCH_PERF_CNT_EN.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        pc_sel_i,
    input  logic [31:0] br_target_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] redirect_cnt_o
`endif
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_KILL  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        req_q, req_d;
    logic        skid_vld_q, skid_vld_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic        if_vld_q, if_vld_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;

    logic        fire;
    logic        resp_vld;
    logic        if_free;

    // req_q is only ever high in FETCH, so a grant is meaningful only then
    assign fire     = req_q & imem_gnt_i;
    assign resp_vld = (state_q == S_WAIT) & imem_rvalid_i;
    assign if_free  = ~if_vld_q | ~stall_i;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        skid_vld_d   = skid_vld_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        if_vld_d     = if_vld_q;
        if_pc_d      = if_pc_q;
        if_instr_d   = if_instr_q;

        if (pc_sel_i) begin
            pc_d       = br_target_i & ~32'h3;
            if_vld_d   = 1'b0;
            skid_vld_d = 1'b0;
            case (state_q)
                S_FETCH: if (fire) state_d = S_KILL;
                S_WAIT:  state_d = imem_rvalid_i ? S_FETCH : S_KILL;
                S_KILL:  state_d = imem_rvalid_i ? S_FETCH : S_KILL;
                default: state_d = S_FETCH;
            endcase
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (fire) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + 32'd4;
                        state_d  = S_WAIT;
                    end
                end
                S_WAIT:  if (imem_rvalid_i) state_d = S_FETCH;
                S_KILL:  if (imem_rvalid_i) state_d = S_FETCH;
                default: state_d = S_FETCH;
            endcase

            // Skid content is older than any new response, so it goes first
            if (!stall_i && skid_vld_q) begin
                if_vld_d   = 1'b1;
                if_pc_d    = skid_pc_q;
                if_instr_d = skid_instr_q;
                skid_vld_d = 1'b0;
                if (resp_vld) begin
                    skid_vld_d   = 1'b1;
                    skid_pc_d    = req_pc_q;
                    skid_instr_d = imem_rdata_i;
                end
            end else if (if_free) begin
                if (resp_vld) begin
                    if_vld_d   = 1'b1;
                    if_pc_d    = req_pc_q;
                    if_instr_d = imem_rdata_i;
                end else if (!stall_i) begin
                    if_vld_d = 1'b0;
                end
            end else if (resp_vld) begin
                skid_vld_d   = 1'b1;
                skid_pc_d    = req_pc_q;
                skid_instr_d = imem_rdata_i;
            end
        end

        req_d = (state_d == S_FETCH) & ~skid_vld_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            req_pc_q     <= 32'h0;
            req_q        <= 1'b0;
            skid_vld_q   <= 1'b0;
            skid_pc_q    <= 32'h0;
            skid_instr_q <= NOP;
            if_vld_q     <= 1'b0;
            if_pc_q      <= 32'h0;
            if_instr_q   <= NOP;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            req_q        <= req_d;
            skid_vld_q   <= skid_vld_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            if_vld_q     <= if_vld_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
        end
    end

    assign imem_req_o  = req_q;
    assign imem_addr_o = pc_q;
    assign if_valid_o  = if_vld_q;
    assign if_pc_o     = if_pc_q;
    assign if_instr_o  = if_instr_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] redirect_cnt_q, redirect_cnt_d;

    // Killed responses never reach IF/ID or the skid, so they are not counted
    always_comb begin
        fetch_cnt_d    = fetch_cnt_q;
        redirect_cnt_d = redirect_cnt_q;
        if (resp_vld && !pc_sel_i) fetch_cnt_d = fetch_cnt_q + 32'd1;
        if (pc_sel_i) redirect_cnt_d = redirect_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_cnt_q    <= 32'h0;
            redirect_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q    <= fetch_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign fetch_cnt_o    = fetch_cnt_q;
    assign redirect_cnt_o = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with a one-outstanding instruction memory responder.
module tb_fetch_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        pc_sel;
    logic [31:0] br_target;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] redirect_cnt;
`endif

    int          tests = 0;
    int          fails = 0;

    logic        mem_pend;
    int          mem_cnt;
    int          mem_delay;
    logic [31:0] mem_addr;

    fetch_pc_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .pc_sel_i      (pc_sel),
        .br_target_i   (br_target),
        .stall_i       (stall),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_gnt_i    (imem_gnt),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata),
        .if_valid_o    (if_valid),
        .if_pc_o       (if_pc),
        .if_instr_o    (if_instr)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt_o   (fetch_cnt),
        .redirect_cnt_o(redirect_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample the request before the edge, then drive the memory response #1 after it.
    // Memory word at address A is A ^ 32'hDEAD_0000.
    task automatic tick();
        logic        f;
        logic [31:0] a;
        f = imem_req && imem_gnt;
        a = imem_addr;
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        if (f) begin
            mem_pend = 1'b1;
            mem_cnt  = mem_delay;
            mem_addr = a;
        end
        if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_addr ^ 32'hDEAD_0000;
                mem_pend    = 1'b0;
            end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        pc_sel      = 1'b0;
        br_target   = 32'h0;
        stall       = 1'b0;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        mem_pend    = 1'b0;
        mem_cnt     = 0;
        mem_delay   = 1;
        mem_addr    = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_instr", if_instr, 32'h0000_0013);
        chk("rst_addr", imem_addr, 32'h0000_0100);
        rst_n = 1'b1;

        // Sequential fetch from RESET_PC with a 1-cycle memory
        tick();
        chk("seq_req0", {31'b0, imem_req}, 32'd1);
        chk("seq_addr0", imem_addr, 32'h0000_0100);
        tick();
        chk("seq_req_wait", {31'b0, imem_req}, 32'd0);
        chk("seq_valid_early", {31'b0, if_valid}, 32'd0);
        tick();
        chk("seq_valid0", {31'b0, if_valid}, 32'd1);
        chk("seq_pc0", if_pc, 32'h0000_0100);
        chk("seq_instr0", if_instr, 32'hDEAD_0100);
        chk("seq_addr1", imem_addr, 32'h0000_0104);
        tick();
        chk("seq_gap", {31'b0, if_valid}, 32'd0);
        tick();
        chk("seq_pc1", if_pc, 32'h0000_0104);
        chk("seq_instr1", if_instr, 32'hDEAD_0104);
        chk("seq_addr2", imem_addr, 32'h0000_0108);
        tick();
        tick();
        chk("seq_valid2", {31'b0, if_valid}, 32'd1);
        chk("seq_pc2", if_pc, 32'h0000_0108);

        // Stall for 4 cycles with a response in flight: it must park in the skid
        stall = 1'b1;
        tick();
        chk("stl_hold_pc1", if_pc, 32'h0000_0108);
        chk("stl_req1", {31'b0, imem_req}, 32'd0);
        tick();
        chk("stl_hold_pc2", if_pc, 32'h0000_0108);
        chk("stl_req2", {31'b0, imem_req}, 32'd0);
        tick();
        chk("stl_req3", {31'b0, imem_req}, 32'd0);
        tick();
        chk("stl_req4", {31'b0, imem_req}, 32'd0);
        chk("stl_hold_instr", if_instr, 32'hDEAD_0108);
        chk("stl_hold_valid", {31'b0, if_valid}, 32'd1);
        stall = 1'b0;
        tick();
        chk("skid_pc", if_pc, 32'h0000_010C);
        chk("skid_instr", if_instr, 32'hDEAD_010C);
        chk("skid_req", {31'b0, imem_req}, 32'd1);
        chk("skid_addr", imem_addr, 32'h0000_0110);
        tick();
        chk("skid_nodup", {31'b0, if_valid}, 32'd0);
        tick();
        chk("skid_next_pc", if_pc, 32'h0000_0110);
        chk("skid_next_instr", if_instr, 32'hDEAD_0110);

        // Redirect during WAIT (under stall), response arrives 3 cycles after the grant
        mem_delay = 3;
        stall = 1'b1;
        tick();
        chk("wr_hold_valid", {31'b0, if_valid}, 32'd1);
        pc_sel    = 1'b1;
        br_target = 32'h0000_0203;
        tick();
        pc_sel = 1'b0;
        stall  = 1'b0;
        chk("wr_flush_valid", {31'b0, if_valid}, 32'd0);
        chk("wr_addr", imem_addr, 32'h0000_0200);
        chk("wr_req_kill", {31'b0, imem_req}, 32'd0);
        tick();
        chk("wr_kill_wait", {31'b0, imem_req}, 32'd0);
        tick();
        chk("wr_drop_valid", {31'b0, if_valid}, 32'd0);
        chk("wr_refetch_req", {31'b0, imem_req}, 32'd1);
        chk("wr_refetch_addr", imem_addr, 32'h0000_0200);
        mem_delay = 1;
        tick();
        tick();
        chk("wr_tgt_pc", if_pc, 32'h0000_0200);
        chk("wr_tgt_instr", if_instr, 32'hDEAD_0200);

        // Redirect to 0x10 without a grant, then redirect again in the grant cycle at 0x10
        imem_gnt  = 1'b0;
        pc_sel    = 1'b1;
        br_target = 32'h0000_0010;
        tick();
        pc_sel   = 1'b0;
        imem_gnt = 1'b1;
        chk("gr_addr10", imem_addr, 32'h0000_0010);
        chk("gr_req10", {31'b0, imem_req}, 32'd1);
        pc_sel    = 1'b1;
        br_target = 32'h0000_0040;
        tick();
        pc_sel = 1'b0;
        chk("gr_kill_req", {31'b0, imem_req}, 32'd0);
        chk("gr_kill_addr", imem_addr, 32'h0000_0040);
        chk("gr_kill_valid", {31'b0, if_valid}, 32'd0);
        tick();
        chk("gr_drop_valid", {31'b0, if_valid}, 32'd0);
        chk("gr_refetch", {31'b0, imem_req}, 32'd1);
        tick();
        tick();
        chk("gr_tgt_pc", if_pc, 32'h0000_0040);
        chk("gr_tgt_instr", if_instr, 32'hDEAD_0040);

        // PC wrap at the top of the address space; low target bits ignored
        imem_gnt  = 1'b0;
        pc_sel    = 1'b1;
        br_target = 32'hFFFF_FFFF;
        tick();
        pc_sel   = 1'b0;
        imem_gnt = 1'b1;
        chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr_zero", imem_addr, 32'h0000_0000);
        tick();
        chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_instr", if_instr, 32'h2152_FFFC);
        chk("wrap_req", {31'b0, imem_req}, 32'd1);

`ifdef FETCH_PERF_CNT_EN
        chk("cnt_fetch", fetch_cnt, 32'd8);
        chk("cnt_redirect", redirect_cnt, 32'd4);
`endif

        // Asynchronous reset while waiting on a response under stall
        stall     = 1'b1;
        mem_delay = 3;
        tick();
        chk("ar_wait_req", {31'b0, imem_req}, 32'd0);
        rst_n       = 1'b0;
        mem_pend    = 1'b0;
        imem_rvalid = 1'b0;
        #1;
        chk("ar_req", {31'b0, imem_req}, 32'd0);
        chk("ar_valid", {31'b0, if_valid}, 32'd0);
        chk("ar_pc", if_pc, 32'h0);
        chk("ar_instr", if_instr, 32'h0000_0013);
        chk("ar_addr", imem_addr, 32'h0000_0100);
`ifdef FETCH_PERF_CNT_EN
        chk("ar_cnt_fetch", fetch_cnt, 32'd0);
        chk("ar_cnt_redirect", redirect_cnt, 32'd0);
`endif
        stall     = 1'b0;
        mem_delay = 1;
        rst_n     = 1'b1;
        tick();
        chk("ar_restart_req", {31'b0, imem_req}, 32'd1);
        chk("ar_restart_addr", imem_addr, 32'h0000_0100);
        tick();
        tick();
        chk("ar_restart_pc", if_pc, 32'h0000_0100);
        chk("ar_restart_instr", if_instr, 32'hDEAD_0100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- IF-stage PC generator and instruction fetcher. Sits directly upstream of decode; its branch-redirect input is driven by the EX-stage branch resolution unit (pc_sel / target).
- Holds the architectural fetch PC and issues word fetches on a req/gnt/rvalid instruction-memory port, with at most one request outstanding.
- Presents {valid, pc, instr} in the IF/ID register, honours hazard stalls, and kills wrong-path fetches on redirect.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset (word aligned).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- pc_sel_i  in  1  taken-branch/jump redirect from EX; single-cycle pulse.
- br_target_i  in  32  redirect target; valid when pc_sel_i=1.
- stall_i  in  1  hazard unit holds the IF/ID register.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  fetch address; stable while req high and not granted.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  read data valid; at least 1 cycle after gnt.
- imem_rdata_i  in  32  instruction word.
- if_valid_o  out  1  IF/ID holds a valid instruction.
- if_pc_o  out  32  PC of if_instr_o.
- if_instr_o  out  32  fetched instruction.

Behaviour:
- Reset (async, rst_ni=0): pc_q=RESET_PC, state=FETCH, imem_req_o=0, if_valid_o=0, if_pc_o=0, if_instr_o=32'h0000_0013 (NOP), skid buffer empty. The first request is issued in the first cycle after rst_ni deasserts. Reset asserted mid-transaction abandons it; the memory is reset by the same rst_ni.
- imem_addr_o = pc_q. pc_q[1:0] is always 0; br_target_i[1:0] is ignored.
- FSM states:
  - FETCH: imem_req_o=1 unless the skid buffer is full. On gnt: latch req_pc=pc_q, pc_q<=pc_q+4 (32-bit wrap; 32'hFFFF_FFFC -> 0), go to WAIT.
  - WAIT: imem_req_o=0. On rvalid: deliver {req_pc, rdata}, go to FETCH.
  - KILL: imem_req_o=0. On rvalid: discard the data, go to FETCH.
- Delivery:
  - When the IF/ID register is free (if_valid_o=0 or stall_i=0), the response loads IF/ID directly.
  - Otherwise it goes to a 1-entry skid buffer, and no new request is issued until the skid buffer drains.
  - When stall_i=0, IF/ID loads from the skid buffer first if it is occupied. If nothing is available, if_valid_o<=0.
  - While stall_i=1, IF/ID holds its value.
- Redirect (pc_sel_i=1) has priority over everything, including stall_i:
  - pc_q<=br_target_i with low 2 bits cleared; if_valid_o<=0; skid buffer cleared.
  - In FETCH with gnt in the same cycle: the granted request is wrong-path, so go to KILL.
  - In WAIT without rvalid in the same cycle: go to KILL.
  - In WAIT or KILL with rvalid in the same cycle: drop the data, go to FETCH.
  - In KILL without rvalid: stay in KILL.
- Latency: with gnt in the request cycle and rvalid the next cycle, if_valid_o rises 2 cycles after req. Back-to-back throughput with 1-cycle memory is 1 instruction per 2 cycles.
- One redirect pulse per branch. A second pulse before the killed response returns just updates pc_q and stays in KILL.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds output ports fetch_cnt_o[31:0] and redirect_cnt_o[31:0], both reset to 0 and wrapping.
  - fetch_cnt_o increments for each response delivered to IF/ID or the skid buffer; killed responses are not counted.
  - redirect_cnt_o increments for each cycle with pc_sel_i=1.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset release, RESET_PC=0x100, gnt tied to 1, 1-cycle rvalid -> addresses 0x100, 0x104, 0x108; if_pc_o follows the same sequence with matching instr; if_valid_o first high 2 cycles after the first req.
- stall_i held 4 cycles while a response is pending -> IF/ID unchanged, skid buffer captures the response, req low. After release: skid instr, then the next fetch, with no loss or duplication.
- pc_sel_i with br_target_i=0x203 while in WAIT, rvalid 3 cycles later -> if_valid_o=0 next cycle, that response discarded, next imem_addr_o=0x200.
- pc_sel_i in the same cycle as gnt at 0x10 -> its response dropped, next fetch at the target; PC 0x10 never appears on if_pc_o.
- pc_q=0xFFFF_FFFC fetched -> next imem_addr_o=0x0000_0000.
- rst_ni pulsed low while in WAIT with stall_i=1 -> all outputs at their reset values immediately; fetch restarts at RESET_PC. With FETCH_PERF_CNT_EN defined, both counters read 0.
